tdpr_fifo_ctrl: RTL and testbench

- Synchronous FIFO controller that sits directly upstream of the True_DPR dual-port RAM and drives both of its ports.
- Port A is used only for writes (push side). Port B is used only for reads (pop side).
- Presents a first-word-fall-through, valid/ready stream on each side.
- Hides the RAM's 1-cycle registered read latency with a single output stage, so throughput is 1 word per cycle.

---
 rtl/tdpr_fifo_ctrl_pkg.sv | 16 +
 rtl/tdpr_fifo_ctrl_if.sv | 23 ++
 rtl/tdpr_fifo_ctrl.sv | 104 ++++++++++
 tb/tb_tdpr_fifo_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/tdpr_fifo_ctrl_pkg.sv
// rtl/tdpr_fifo_ctrl_pkg.sv - shared types and helpers for the True_DPR FIFO controller
package tdpr_fifo_ctrl_pkg;

    // Output stage: nothing, word arriving from RAM this cycle, word parked in hold register
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FRESH = 2'd1,
        HELD  = 2'd2
    } out_state_t;

    // Pointer increment with wrap at the RAM depth
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
        return (ptr + 32'd1 >= depth) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/tdpr_fifo_ctrl_if.sv
// rtl/tdpr_fifo_ctrl_if.sv - push/pop valid-ready streams of the FIFO controller
interface tdpr_fifo_ctrl_if #(
    parameter int DATA_SIZE = 8
);
    logic                 wr_valid;
    logic                 wr_ready;
    logic [DATA_SIZE-1:0] wr_data;
    logic                 rd_valid;
    logic                 rd_ready;
    logic [DATA_SIZE-1:0] rd_data;

    // master: producer and consumer attached to the FIFO
    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data
    );

    // slave: the FIFO controller itself
    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/tdpr_fifo_ctrl.sv
// rtl/tdpr_fifo_ctrl.sv - FWFT FIFO controller driving both ports of a True_DPR RAM
module tdpr_fifo_ctrl
    import tdpr_fifo_ctrl_pkg::*;
#(
    parameter int          ADDR_SIZE = 8,
    parameter int          DATA_SIZE = 8,
    parameter int unsigned RAM_SIZE  = 1 << ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    tdpr_fifo_ctrl_if.slave      strm,
    output logic [ADDR_SIZE:0]   count,
    output logic                 ram_en_a,
    output logic                 ram_we_a,
    output logic [ADDR_SIZE-1:0] ram_addr_a,
    output logic [DATA_SIZE-1:0] ram_din_a,
    output logic                 ram_en_b,
    output logic                 ram_we_b,
    output logic [ADDR_SIZE-1:0] ram_addr_b,
    input  logic [DATA_SIZE-1:0] ram_dout_b
);

    localparam logic [ADDR_SIZE:0] OCC_ONE = {{ADDR_SIZE{1'b0}}, 1'b1};

    out_state_t           state;
    logic [ADDR_SIZE-1:0] wr_ptr;
    logic [ADDR_SIZE-1:0] rd_ptr;
    logic [ADDR_SIZE:0]   ram_occ;
    logic [DATA_SIZE-1:0] hold_q;

    logic rd_valid_w;
    logic wr_ready_w;
    logic accept;
    logic pop;
    logic fetch;

    assign rd_valid_w = (state != EMPTY);
    assign count      = ram_occ + {{ADDR_SIZE{1'b0}}, rd_valid_w};
    assign wr_ready_w = !rst && (count != (ADDR_SIZE+1)'(RAM_SIZE));
    assign accept     = strm.wr_valid && wr_ready_w;
    assign pop        = rd_valid_w && strm.rd_ready;
    // Refill the output stage whenever it is empty or being drained this cycle
    assign fetch      = !rst && (ram_occ != '0) && ((state == EMPTY) || pop);

    assign strm.wr_ready = wr_ready_w;
    assign strm.rd_valid = rd_valid_w;
    assign strm.rd_data  = (state == HELD) ? hold_q : ram_dout_b;

    assign ram_en_a   = accept;
    assign ram_we_a   = accept;
    assign ram_addr_a = wr_ptr;
    assign ram_din_a  = strm.wr_data;
    assign ram_en_b   = fetch;
    assign ram_we_b   = 1'b0;
    assign ram_addr_b = rd_ptr;

    // Pointers and count of words still resident in RAM
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_occ <= '0;
        end else begin
            if (accept)
                wr_ptr <= ADDR_SIZE'(ptr_next(32'(wr_ptr), RAM_SIZE));
            if (fetch)
                rd_ptr <= ADDR_SIZE'(ptr_next(32'(rd_ptr), RAM_SIZE));
            case ({accept, fetch})
                2'b10:   ram_occ <= ram_occ + OCC_ONE;
                2'b01:   ram_occ <= ram_occ - OCC_ONE;
                default: ram_occ <= ram_occ;
            endcase
        end
    end

    // Output stage: FRESH shows RAM dout directly, HELD keeps it once the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            hold_q <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (fetch)
                        state <= FRESH;
                end
                FRESH: begin
                    if (pop) begin
                        state <= fetch ? FRESH : EMPTY;
                    end else begin
                        state  <= HELD;
                        hold_q <= ram_dout_b;
                    end
                end
                HELD: begin
                    if (pop)
                        state <= fetch ? FRESH : EMPTY;
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_tdpr_fifo_ctrl.sv
// tb/tb_tdpr_fifo_ctrl.sv - scoreboard bench for tdpr_fifo_ctrl with a behavioural True_DPR
module tb_tdpr_fifo_ctrl;

    localparam int AW    = 2;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tdpr_fifo_ctrl_if #(.DATA_SIZE(DW)) bus ();

    logic [AW:0]   count;
    logic          ram_en_a, ram_we_a, ram_en_b, ram_we_b;
    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic [DW-1:0] ram_din_a, ram_dout_b;

    tdpr_fifo_ctrl #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .strm       (bus),
        .count      (count),
        .ram_en_a   (ram_en_a),
        .ram_we_a   (ram_we_a),
        .ram_addr_a (ram_addr_a),
        .ram_din_a  (ram_din_a),
        .ram_en_b   (ram_en_b),
        .ram_we_b   (ram_we_b),
        .ram_addr_b (ram_addr_b),
        .ram_dout_b (ram_dout_b)
    );

    // Behavioural True_DPR: registered read on port B
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_en_a && ram_we_a) mem[ram_addr_a] <= ram_din_a;
        if (ram_en_b && !ram_we_b) ram_dout_b <= mem[ram_addr_b];
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Scoreboard plus expected RAM addresses on each port
    logic [DW-1:0] sb [$];
    int wa = 0;
    int ra = 0;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            wa = 0;
            ra = 0;
        end else begin
            check("count_sb", 32'(count), sb.size());
            check("wr_ready_sb", 32'(bus.wr_ready), 32'(sb.size() != DEPTH));
            check("we_b", 32'(ram_we_b), 0);
            if (bus.wr_valid && bus.wr_ready) begin
                check("en_a", 32'(ram_en_a && ram_we_a), 1);
                check("addr_a", 32'(ram_addr_a), wa);
                check("din_a", 32'(ram_din_a), 32'(bus.wr_data));
                sb.push_back(bus.wr_data);
                wa = (wa + 1) % DEPTH;
            end else begin
                check("en_a_idle", 32'(ram_en_a), 0);
            end
            if (ram_en_b) begin
                check("addr_b", 32'(ram_addr_b), ra);
                if (ram_en_a) check("collide", 32'(ram_addr_a == ram_addr_b), 0);
                ra = (ra + 1) % DEPTH;
            end
            if (bus.rd_valid && bus.rd_ready) begin
                if (sb.size() == 0) check("pop_empty", 1, 0);
                else                check("rd_data_sb", 32'(bus.rd_data), 32'(sb.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;

        // 1: reset
        repeat (3) begin
            tick();
            check("rst_rd_valid", 32'(bus.rd_valid), 0);
            check("rst_count", 32'(count), 0);
            check("rst_en_a", 32'(ram_en_a), 0);
            check("rst_en_b", 32'(ram_en_b), 0);
            check("rst_wr_ready", 32'(bus.wr_ready), 0);
        end
        rst = 1'b0;
        #1;
        check("post_rst_wr_ready", 32'(bus.wr_ready), 1);
        check("post_rst_count", 32'(count), 0);

        // 2: single word latency
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hA1;
        #1;
        check("t2_en_a", 32'(ram_en_a), 1);
        check("t2_addr_a", 32'(ram_addr_a), 0);
        check("t2_din_a", 32'(ram_din_a), 32'h A1);
        tick();
        bus.wr_valid = 1'b0;
        #1;
        check("t2_en_b", 32'(ram_en_b), 1);
        check("t2_addr_b", 32'(ram_addr_b), 0);
        check("t2_c1_rd_valid", 32'(bus.rd_valid), 0);
        tick();
        check("t2_rd_valid", 32'(bus.rd_valid), 1);
        check("t2_rd_data", 32'(bus.rd_data), 32'h A1);
        check("t2_count", 32'(count), 1);
        bus.rd_ready = 1'b1;
        tick();
        bus.rd_ready = 1'b0;
        check("t2_pop_count", 32'(count), 0);
        check("t2_pop_rd_valid", 32'(bus.rd_valid), 0);

        // 3: fill to capacity, fifth push refused
        for (int i = 0; i < 5; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 8'(8'h11 * (i + 1));
            #1;
            if (i == 4) begin
                check("t3_full_wr_ready", 32'(bus.wr_ready), 0);
                check("t3_full_en_a", 32'(ram_en_a), 0);
            end else begin
                check("t3_wr_ready", 32'(bus.wr_ready), 1);
            end
            tick();
        end
        bus.wr_valid = 1'b0;
        check("t3_count", 32'(count), 4);

        // 4: stalled head stays stable, then drains back to back
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_hold_valid", 32'(bus.rd_valid), 1);
            check("t4_hold_data", 32'(bus.rd_data), 32'h11);
        end
        bus.rd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t4_drain_valid", 32'(bus.rd_valid), 1);
            check("t4_drain_data", 32'(bus.rd_data), 32'(8'h11 * (k + 1)));
            tick();
        end
        check("t4_empty_valid", 32'(bus.rd_valid), 0);
        check("t4_empty_count", 32'(count), 0);

        // 5: streaming with wrap, continuous output from cycle 2
        for (int i = 0; i < 18; i++) begin
            bus.wr_valid = (i < 16);
            bus.wr_data  = 8'(8'h30 + i);
            #1;
            if (i < 16) check("t5_wr_ready", 32'(bus.wr_ready), 1);
            if (i >= 2) begin
                check("t5_rd_valid", 32'(bus.rd_valid), 1);
                check("t5_rd_data", 32'(bus.rd_data), 32'(8'h30 + i - 2));
            end else begin
                check("t5_early_rd_valid", 32'(bus.rd_valid), 0);
            end
            tick();
        end
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
        check("t5_end_count", 32'(count), 0);

        // 6: reset while full with push and pop pending
        for (int i = 0; i < 4; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 8'(8'hC0 + i);
            tick();
        end
        check("t6_full_count", 32'(count), 4);
        bus.wr_data  = 8'hC4;
        bus.rd_ready = 1'b1;
        rst          = 1'b1;
        #1;
        check("t6_rst_wr_ready", 32'(bus.wr_ready), 0);
        check("t6_rst_en_a", 32'(ram_en_a), 0);
        check("t6_rst_en_b", 32'(ram_en_b), 0);
        tick();
        rst          = 1'b0;
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
        #1;
        check("t6_post_count", 32'(count), 0);
        check("t6_post_rd_valid", 32'(bus.rd_valid), 0);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hE7;
        #1;
        check("t6_addr_a", 32'(ram_addr_a), 0);
        tick();
        bus.wr_valid = 1'b0;
        #1;
        check("t6_en_b", 32'(ram_en_b), 1);
        check("t6_addr_b", 32'(ram_addr_b), 0);
        tick();
        check("t6_rd_valid", 32'(bus.rd_valid), 1);
        check("t6_rd_data", 32'(bus.rd_data), 32'h E7);
        bus.rd_ready = 1'b1;
        tick();
        bus.rd_ready = 1'b0;
        check("t6_final_count", 32'(count), 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
